// File: rtl/solution_unpacker.sv
// Solution frame unpacker: decodes a UART byte stream carrying a board
// solution (header, two bytes per row, checksum) into a flat cell grid.
// Frames that are malformed, carry a bad checksum, or stall for too long
// are rejected with a single-cycle error pulse.
module solution_unpacker #(
    parameter int MAX_ROWS       = 11,
    parameter int MAX_COLS       = 11,
    parameter int TIMEOUT_CYCLES = 500_000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         valid_in,
    input  logic [7:0]                   byte_in,
    output logic [MAX_ROWS*MAX_COLS-1:0] solution,
    output logic [3:0]                   m,
    output logic [3:0]                   n,
    output logic                         done,
    output logic                         error,
    output logic                         busy
);

    localparam int CELLS = MAX_ROWS * MAX_COLS;
    localparam int IW    = (CELLS > 1) ? $clog2(CELLS) : 1;
    localparam int TW    = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [1:0] {
        IDLE,
        ROW_LO,
        ROW_HI,
        CHECK
    } state_t;

    state_t           state_q, state_d;
    logic [CELLS-1:0] sol_q, sol_d;
    logic [3:0]       m_q, m_d;
    logic [3:0]       n_q, n_d;
    logic [3:0]       row_q, row_d;
    logic [7:0]       csum_q, csum_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic             done_q, done_d;
    logic             error_q, error_d;

    logic [3:0]       hdrM;
    logic [3:0]       hdrN;
    logic             hdrOk;
    logic             tmoHit;

    // Header field extraction, range check, and the stall detector: the
    // counter expires on the cycle its next value would reach the limit.
    always_comb begin
        hdrM   = byte_in[7:4];
        hdrN   = byte_in[3:0];
        hdrOk  = (hdrM != 4'd0) && (int'(hdrM) <= MAX_ROWS) &&
                 (hdrN != 4'd0) && (int'(hdrN) <= MAX_COLS);
        tmoHit = (tmo_q >= TW'(TIMEOUT_CYCLES - 1));
    end

    // Next-state logic: frame parsing, row writes with column masking,
    // running checksum, and abort on stall.
    always_comb begin
        state_d = state_q;
        sol_d   = sol_q;
        m_d     = m_q;
        n_d     = n_q;
        row_d   = row_q;
        csum_d  = csum_q;
        tmo_d   = tmo_q;
        done_d  = 1'b0;
        error_d = 1'b0;

        if (state_q == IDLE) begin
            tmo_d = '0;
            if (valid_in) begin
                if (hdrOk) begin
                    m_d     = hdrM;
                    n_d     = hdrN;
                    sol_d   = '0;
                    row_d   = 4'd0;
                    csum_d  = byte_in;
                    state_d = ROW_LO;
                end else begin
                    error_d = 1'b1;
                end
            end
        end else if (valid_in) begin
            tmo_d = '0;
            case (state_q)
                ROW_LO: begin
                    for (int r = 0; r < MAX_ROWS; r++) begin
                        if (int'(row_q) == r) begin
                            for (int c = 0; c < MAX_COLS; c++) begin
                                if (c < 8) begin
                                    sol_d[IW'(r*MAX_COLS + c)] =
                                        (c < int'(n_q)) ? byte_in[3'(c)] : 1'b0;
                                end
                            end
                        end
                    end
                    csum_d  = csum_q ^ byte_in;
                    state_d = ROW_HI;
                end
                ROW_HI: begin
                    for (int r = 0; r < MAX_ROWS; r++) begin
                        if (int'(row_q) == r) begin
                            for (int c = 0; c < MAX_COLS; c++) begin
                                if (c >= 8 && c < 11) begin
                                    sol_d[IW'(r*MAX_COLS + c)] =
                                        (c < int'(n_q)) ? byte_in[3'(c - 8)] : 1'b0;
                                end
                            end
                        end
                    end
                    csum_d = csum_q ^ byte_in;
                    if (row_q == m_q - 4'd1) begin
                        state_d = CHECK;
                    end else begin
                        row_d   = row_q + 4'd1;
                        state_d = ROW_LO;
                    end
                end
                CHECK: begin
                    if (byte_in == csum_q) begin
                        done_d = 1'b1;
                    end else begin
                        error_d = 1'b1;
                        sol_d   = '0;
                        m_d     = 4'd0;
                        n_d     = 4'd0;
                    end
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end else if (tmoHit) begin
            error_d = 1'b1;
            sol_d   = '0;
            m_d     = 4'd0;
            n_d     = 4'd0;
            tmo_d   = '0;
            state_d = IDLE;
        end else begin
            tmo_d = tmo_q + TW'(1);
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sol_q   <= '0;
            m_q     <= 4'd0;
            n_q     <= 4'd0;
            row_q   <= 4'd0;
            csum_q  <= 8'd0;
            tmo_q   <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sol_q   <= sol_d;
            m_q     <= m_d;
            n_q     <= n_d;
            row_q   <= row_d;
            csum_q  <= csum_d;
            tmo_q   <= tmo_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    assign solution = sol_q;
    assign m        = m_q;
    assign n        = n_q;
    assign done     = done_q;
    assign error    = error_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_solution_unpacker.sv
// Scoreboard bench for solution_unpacker: the driver predicts each frame's
// outcome from the frame rules and queues it; a monitor checks pulses.
module tb_solution_unpacker;

    localparam int MR    = 11;
    localparam int MC    = 11;
    localparam int TO    = 100;
    localparam int CELLS = MR * MC;

    typedef logic [7:0] bq_t[$];

    typedef struct {
        bit               isDone;
        logic [3:0]       em;
        logic [3:0]       en;
        logic [CELLS-1:0] sol;
        int               at;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             valid_in;
    logic [7:0]       byte_in;
    logic [CELLS-1:0] solution;
    logic [3:0]       m;
    logic [3:0]       n;
    logic             done;
    logic             error;
    logic             busy;

    int               cyc = 0;
    int               total = 0;
    int               bad = 0;
    int               lastAt = 0;
    exp_t             expQ[$];
    logic [CELLS-1:0] curSol = '0;
    logic [3:0]       curM = 4'd0;
    logic [3:0]       curN = 4'd0;

    solution_unpacker #(
        .MAX_ROWS(MR),
        .MAX_COLS(MC),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .valid_in(valid_in),
        .byte_in(byte_in),
        .solution(solution),
        .m(m),
        .n(n),
        .done(done),
        .error(error),
        .busy(busy)
    );

    // Free-running clock and edge counter used to time pulses.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [127:0] act,
                               input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: every done/error pulse must match the oldest prediction.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && (done || error)) begin
            if (expQ.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected pulse: done=%0b error=%0b at cycle %0d, expected none",
                         done, error, cyc);
            end else begin
                e = expQ.pop_front();
                checkOutput("pulse done", done, e.isDone);
                checkOutput("pulse error", error, !e.isDone);
                checkOutput("pulse cycle", cyc, e.at);
                checkOutput("pulse m", m, e.em);
                checkOutput("pulse n", n, e.en);
                checkOutput("pulse solution", solution, e.sol);
            end
        end
    end

    // Reference model: outcome of a complete frame from the frame rules.
    task automatic predict(input bq_t fr, input int at);
        exp_t       e;
        logic [7:0] h, b, x;
        int         mm, nn;
        logic [CELLS-1:0] s;
        h  = fr[0];
        mm = int'(h[7:4]);
        nn = int'(h[3:0]);
        if (mm < 1 || mm > MR || nn < 1 || nn > MC) begin
            e = '{isDone: 1'b0, em: curM, en: curN, sol: curSol, at: at};
            expQ.push_back(e);
            return;
        end
        x = 8'd0;
        for (int i = 0; i < fr.size() - 1; i++) x = x ^ fr[i];
        s = '0;
        for (int r = 0; r < mm; r++) begin
            for (int c = 0; c < nn; c++) begin
                if (c < 8) begin
                    b = fr[1 + 2*r];
                    s[7'(r*MC + c)] = b[3'(c)];
                end else begin
                    b = fr[2 + 2*r];
                    s[7'(r*MC + c)] = b[3'(c - 8)];
                end
            end
        end
        if (fr[fr.size() - 1] == x) begin
            curSol = s;
            curM   = h[7:4];
            curN   = h[3:0];
            e = '{isDone: 1'b1, em: curM, en: curN, sol: curSol, at: at};
        end else begin
            curSol = '0;
            curM   = 4'd0;
            curN   = 4'd0;
            e = '{isDone: 1'b0, em: 4'd0, en: 4'd0, sol: '0, at: at};
        end
        expQ.push_back(e);
    endtask

    task automatic sendByte(input logic [7:0] b);
        @(negedge clk);
        valid_in = 1'b1;
        byte_in  = b;
        lastAt   = cyc + 1;
    endtask

    task automatic idle(input int k);
        repeat (k) begin
            @(negedge clk);
            valid_in = 1'b0;
            byte_in  = 8'($urandom);
        end
    endtask

    task automatic makeFrame(input int mm, input int nn, input bit goodSum,
                             output bq_t fr);
        logic [7:0] x;
        fr.delete();
        fr.push_back({4'(mm), 4'(nn)});
        x = fr[0];
        for (int i = 0; i < 2*mm; i++) begin
            fr.push_back(8'($urandom));
            x = x ^ fr[fr.size() - 1];
        end
        if (!goodSum) x = x ^ 8'($urandom_range(255, 1));
        fr.push_back(x);
    endtask

    task automatic applyStimulus(input bq_t fr, input int gapMax);
        for (int i = 0; i < fr.size(); i++) begin
            sendByte(fr[i]);
            if (i < fr.size() - 1 && gapMax > 0) idle($urandom_range(gapMax, 0));
        end
        predict(fr, lastAt);
        idle(1);
    endtask

    // Directed scenarios followed by randomized frames.
    initial begin
        bq_t        fr;
        logic [7:0] h;
        int         hAt;
        exp_t       e;

        rst      = 1'b1;
        valid_in = 1'b0;
        byte_in  = 8'h00;
        repeat (3) @(negedge clk);
        checkOutput("reset busy", busy, 1'b0);
        checkOutput("reset done", done, 1'b0);
        checkOutput("reset error", error, 1'b0);
        checkOutput("reset m", m, 4'd0);
        checkOutput("reset n", n, 4'd0);
        checkOutput("reset solution", solution, '0);
        rst = 1'b0;

        // 3x3 frame; XOR of 33,FF,07,00,00,05,00 is CE.
        fr = '{8'h33, 8'hFF, 8'h07, 8'h00, 8'h00, 8'h05, 8'h00, 8'hCE};
        applyStimulus(fr, 0);
        idle(2);
        checkOutput("3x3 m", m, 4'd3);
        checkOutput("3x3 n", n, 4'd3);
        checkOutput("3x3 solution", solution, 121'h1400007);
        checkOutput("3x3 busy", busy, 1'b0);

        // Same frame with wrong checksums.
        fr[7] = 8'h00;
        applyStimulus(fr, 0);
        idle(2);
        checkOutput("badsum m", m, 4'd0);
        checkOutput("badsum solution", solution, '0);
        fr[7] = 8'hFE;
        applyStimulus(fr, 1);

        // Full 11x11 frame, back-to-back bytes.
        makeFrame(11, 11, 1'b1, fr);
        applyStimulus(fr, 0);
        idle(2);
        checkOutput("11x11 busy", busy, 1'b0);
        checkOutput("11x11 m", m, 4'd11);

        // Out-of-range headers, then a normal frame.
        h = 8'hC5;
        sendByte(h);
        fr = '{h};
        predict(fr, lastAt);
        idle(1);
        checkOutput("hdr C5 busy", busy, 1'b0);
        h = 8'h30;
        sendByte(h);
        fr = '{h};
        predict(fr, lastAt);
        idle(1);
        checkOutput("hdr 30 busy", busy, 1'b0);
        makeFrame(4, 9, 1'b1, fr);
        applyStimulus(fr, 2);

        // Stall after a header: error exactly TO edges after it.
        sendByte(8'h22);
        hAt = lastAt;
        e = '{isDone: 1'b0, em: 4'd0, en: 4'd0, sol: '0, at: hAt + TO};
        expQ.push_back(e);
        curSol = '0;
        curM   = 4'd0;
        curN   = 4'd0;
        idle(TO + 5);
        checkOutput("timeout busy", busy, 1'b0);

        // Byte arriving on the expiry edge keeps the frame alive.
        makeFrame(2, 2, 1'b1, fr);
        sendByte(fr[0]);
        idle(TO - 1);
        for (int i = 1; i < fr.size(); i++) sendByte(fr[i]);
        predict(fr, lastAt);
        idle(3);

        // Reset mid-frame aborts silently.
        makeFrame(3, 3, 1'b1, fr);
        sendByte(fr[0]);
        sendByte(fr[1]);
        sendByte(fr[2]);
        @(negedge clk);
        valid_in = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        curSol = '0;
        curM   = 4'd0;
        curN   = 4'd0;
        checkOutput("midrst busy", busy, 1'b0);
        checkOutput("midrst m", m, 4'd0);
        checkOutput("midrst n", n, 4'd0);
        checkOutput("midrst solution", solution, '0);
        applyStimulus(fr, 0);

        // Randomized frames and bad headers.
        for (int k = 0; k < 30; k++) begin
            if ($urandom_range(5, 0) == 0) begin
                do h = 8'($urandom);
                while (h[7:4] >= 4'd1 && h[7:4] <= 4'd11 &&
                       h[3:0] >= 4'd1 && h[3:0] <= 4'd11);
                fr = '{h};
                applyStimulus(fr, 0);
            end else begin
                makeFrame($urandom_range(MR, 1), $urandom_range(MC, 1),
                          ($urandom_range(3, 0) != 0), fr);
                applyStimulus(fr, 3);
            end
        end

        for (int w = 0; w < 300 && expQ.size() > 0; w++) @(negedge clk);
        total++;
        if (expQ.size() != 0) begin
            bad++;
            $display("[TB] FAIL drain: %0d pulses still outstanding, expected 0", expQ.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
